dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in the data store (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the cycles from request sample to Done (legal range 1..15).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 MemRead  input  1  load request from the main controller.
REQ-006 MemWrite  input  1  store request from the main controller.
REQ-007 Funct3  input  3  access size/sign (instr[14:12]).
REQ-008 Addr  input  32  byte address from the ALU.
REQ-009 WrData  input  32  store data (rs2).
REQ-010 RdData  output  32  registered, size-adjusted load result.
REQ-011 Stall  output  1  pipeline freeze; high while an access is outstanding.
REQ-012 Done  output  1  one-cycle pulse when the access completes.
REQ-013 Err  output  1  one-cycle pulse for an illegal or misaligned request.

Function
REQ-014 States SHALL be IDLE, BUSY and RESP; a request is sampled only in IDLE.
REQ-015 Request = MemRead | MemWrite; MemRead and MemWrite both high SHALL be illegal.
REQ-016 Legal load Funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal store Funct3: 000 SB, 001 SH, 010 SW; all others SHALL be illegal.
REQ-017 Misaligned: halfword with Addr[0]=1, or word with Addr[1:0]!=00.
REQ-018 Illegal or misaligned request in IDLE: Err=1 for that cycle; no memory access; Stall=0; state stays IDLE; RdData unchanged.
REQ-019 Legal request in IDLE: Addr, WrData, Funct3 and direction captured; Stall=1 combinationally in the same cycle.
REQ-020 LATENCY=1: IDLE->RESP; LATENCY>1: IDLE->BUSY with counter=LATENCY-2; BUSY decrements; BUSY->RESP when counter=0.
REQ-021 Stall SHALL be 1 in BUSY and 0 in RESP; request sampled in cycle 0 yields Done=1 in cycle LATENCY.
REQ-022 RESP SHALL last exactly one cycle, assert Done=1, then return to IDLE.
REQ-023 A store SHALL commit on the RESP edge using byte enables: SB 1 lane (Addr[1:0]), SH 2 lanes (Addr[1]), SW 4 lanes; other bytes preserved.
REQ-024 On a load, RdData SHALL be valid in the RESP cycle (registered on BUSY->RESP or IDLE->RESP edge); LB/LH sign-extend, LBU/LHU zero-extend.
REQ-025 RdData SHALL hold its value outside load completion; stores SHALL NOT alter RdData.
REQ-026 Word index SHALL be Addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around).
REQ-027 Inputs SHALL be ignored in BUSY and RESP; a request present in the cycle after RESP is a new request.

Reset
REQ-028 On reset: state=IDLE, counter=0, RdData=0, Stall=0, Done=0, Err=0.
REQ-029 Reset during BUSY or RESP SHALL abort the access; a pending store SHALL NOT be written.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package riscv_mem_pkg SHALL hold Funct3 load/store encodings, the state enum and the default LATENCY.
REQ-032 Storage SHALL be a sub-module dmem_array: DEPTH_WORDS x 32, 4-bit byte-enable write, synchronous write, combinational read.
REQ-033 Byte-lane steering, extension and the FSM SHALL reside in dmem_responder.

Verification
REQ-034 SW Addr=0x10 WrData=0xDEADBEEF, then LW Addr=0x10 -> each Stall for 2 cycles, Done at cycle 2, RdData=0xDEADBEEF.
REQ-035 After REQ-034: SB Addr=0x11 WrData=0x000000A5; LW 0x10 -> 0xDEADA5EF; LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5.
REQ-036 LH Addr=0x13, SW Addr=0x12, MemRead=MemWrite=1 at Addr 0x0, Funct3=011 load -> Err=1 one cycle each, Stall=0, Done=0, memory and RdData unchanged.
REQ-037 SW Addr=0x20 0x12345678 with reset asserted in the BUSY cycle -> Done never pulses, state IDLE, RdData=0; LW 0x20 returns the prior value.
REQ-038 DEPTH_WORDS=256: SW Addr=0x400 0xCAFEF00D, LW Addr=0x0 -> 0xCAFEF00D (wrap); LATENCY=1: Done in the cycle after the request, Stall high for 1 cycle.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory responder: Funct3 access codes, FSM states, default latency.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Size lives in f3[1:0] for every legal code; illegal codes are rejected separately.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data store: byte-enable synchronous write, combinational read, no reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: validates a load/store, freezes the pipeline, then completes it.
//  state | meaning
//  IDLE  | waiting; legal request accepted, illegal one flagged with Err
//  BUSY  | latency down-counter running toward terminal count 0
//  RESP  | one-cycle completion: Done, store commit
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Stall,
    output logic        Done,
    output logic        Err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [IDX_W+1:0] cap_addr, rd_addr;
    logic [31:0]      cap_wdata;
    logic [2:0]       cap_f3, rd_f3;
    logic             cap_write;
    logic             legal, accept, load_rd;
    logic             we;
    logic [3:0]       be;
    logic [31:0]      wr_word, rd_word, load_val;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^Addr[31:IDX_W+2];

    assign legal = !(MemRead && MemWrite) && f3_legal(MemWrite, Funct3)
                   && !misaligned(Funct3, Addr[1:0]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        Stall     = 1'b0;
        Done      = 1'b0;
        Err       = 1'b0;
        accept    = 1'b0;
        load_rd   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        if (legal) begin
                            accept = 1'b1;
                            Stall  = 1'b1;
                            if (LATENCY == 1) begin
                                state_nxt = RESP;
                                load_rd   = MemRead;
                            end else begin
                                state_nxt = BUSY;
                                cnt_nxt   = CNT_INIT;
                            end
                        end else begin
                            Err = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    Stall = 1'b1;
                    if (cnt == 4'd0) begin
                        state_nxt = RESP;
                        load_rd   = !cap_write;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                RESP: begin
                    Done      = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // With LATENCY=1 the load result is registered straight from the live request.
    assign rd_addr = (state == IDLE) ? Addr[IDX_W+1:0] : cap_addr;
    assign rd_f3   = (state == IDLE) ? Funct3 : cap_f3;

    always_comb begin
        lane_byte = rd_word[{rd_addr[1:0], 3'b000} +: 8];
        lane_half = rd_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (rd_f3)
            F3_B:    load_val = {{24{lane_byte[7]}}, lane_byte};
            F3_H:    load_val = {{16{lane_half[15]}}, lane_half};
            F3_BU:   load_val = {24'd0, lane_byte};
            F3_HU:   load_val = {16'd0, lane_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        be      = 4'b1111;
        wr_word = cap_wdata;
        case (cap_f3)
            F3_B: begin
                be      = 4'b0001 << cap_addr[1:0];
                wr_word = {4{cap_wdata[7:0]}};
            end
            F3_H: begin
                be      = cap_addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{cap_wdata[15:0]}};
            end
            default: ;
        endcase
        we = (state == RESP) && cap_write && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            RdData    <= 32'd0;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
            cap_f3    <= 3'd0;
            cap_write <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_addr  <= Addr[IDX_W+1:0];
                cap_wdata <= WrData;
                cap_f3    <= Funct3;
                cap_write <= MemWrite;
            end
            if (load_rd) RdData <= load_val;
        end
    end

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (we),
        .be    (be),
        .idx   (rd_addr[IDX_W+1:2]),
        .wdata (wr_word),
        .rdata (rd_word)
    );

endmodule
